// File: rtl/instr_decode_ctrl.sv
// Multi-cycle fetch/decode/execute/mem/writeback controller for a tiny load/store ISA.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes latch illegal_op and halt until reset.
module instr_decode_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] i_data,
    output logic [2:0]  state,
    output logic        illegal_op
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_R  = 6'b000000;
    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    state_t       cur;
    state_t       nxt;
    logic [31:11] ir;
    logic [31:0]  result;
    logic         armed;
    logic         transfer;
    logic         is_r;
    logic         is_lw;
    logic         is_sw;
    logic         legal;

    assign is_r  = (ir[31:26] == OP_R);
    assign is_lw = (ir[31:26] == OP_LW);
    assign is_sw = (ir[31:26] == OP_SW);
    assign legal = is_r | is_lw | is_sw;

    // armed holds instr_ready low until the first edge after reset release
    assign instr_ready = armed && (cur == S_FETCH);
    assign transfer    = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur    <= S_FETCH;
            ir     <= '0;
            result <= '0;
            armed  <= 1'b0;
        end else begin
            cur   <= nxt;
            armed <= 1'b1;
            if (transfer)
                ir <= instr[31:11];
            if (cur == S_EXEC)
                result <= alu_result;
            else if (cur == S_MEM && mem_done && is_lw)
                result <= mem_rdata;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:  if (transfer) nxt = S_DECODE;
            S_DECODE: begin
                if (legal)
                    nxt = S_EXEC;
                else
`ifdef ILLEGAL_TRAP_EN
                    nxt = S_HALT;
`else
                    nxt = S_FETCH;
`endif
            end
            S_EXEC:   nxt = is_r ? S_WB : S_MEM;
            S_MEM:    if (mem_done) nxt = is_lw ? S_WB : S_FETCH;
            S_WB:     nxt = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_HALT:   nxt = S_HALT;
`else
            S_HALT:   nxt = S_FETCH;
`endif
            default:  nxt = S_FETCH;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal_q <= 1'b0;
        else if (cur == S_DECODE && !legal)
            illegal_q <= 1'b1;
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    // destination register 0 naturally yields rd=0, so nothing is written
    always_comb begin
        rd = '0;
        if (cur == S_WB)
            rd = is_lw ? ir[20:16] : ir[15:11];
    end

    assign rs      = ir[25:21];
    assign rt      = ir[20:16];
    assign i_data  = result;
    assign mem_req = (cur == S_MEM);
    assign mem_we  = (cur == S_MEM) && is_sw;
    assign state   = cur;

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed self-checking bench for instr_decode_ctrl.
// Define ILLEGAL_TRAP_EN here as well as in the RTL to exercise the trap build.
module tb_instr_decode_ctrl;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_req;
    logic        mem_we;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] i_data;
    logic [2:0]  state;
    logic        illegal_op;

    int errors;
    int checks;

    instr_decode_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_result  (alu_result),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .i_data      (i_data),
        .state       (state),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({state, instr_ready, rd, rs, rt, mem_req, mem_we, illegal_op}
            !== {3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctl: got %h want 0",
                     {state, instr_ready, rd, rs, rt, mem_req, mem_we, illegal_op});
        end
        checks++;
        if (i_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", i_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 0", instr_ready);
        end
        @(negedge clk);
        checks++;
        if ({state, instr_ready} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_first_ready: got %h want 1", {state, instr_ready});
        end
        @(negedge clk);
        checks++;
        if ({state, instr_ready} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL fetch_idle: got %h want 1", {state, instr_ready});
        end
    endtask

    task automatic test_rtype();
        instr_valid = 1'b1;
        instr       = 32'h012A4020;
        alu_result  = 32'h00000055;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL r_ready: got %b want 1", instr_ready);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if ({state, instr_ready, rd, rs, rt} !== {3'd1, 1'b0, 5'd0, 5'd9, 5'd10}) begin
            errors++;
            $display("FAIL r_decode: got %h want %h",
                     {state, instr_ready, rd, rs, rt}, {3'd1, 1'b0, 5'd0, 5'd9, 5'd10});
        end
        @(negedge clk);
        checks++;
        if ({state, rd, i_data} !== {3'd2, 5'd0, 32'h0}) begin
            errors++;
            $display("FAIL r_exec: got %h want %h", {state, rd, i_data}, {3'd2, 5'd0, 32'h0});
        end
        @(negedge clk);
        checks++;
        if ({state, rd, i_data} !== {3'd4, 5'd8, 32'h55}) begin
            errors++;
            $display("FAIL r_wb: got %h want %h", {state, rd, i_data}, {3'd4, 5'd8, 32'h55});
        end
        @(negedge clk);
        checks++;
        if ({state, instr_ready, rd, i_data} !== {3'd0, 1'b1, 5'd0, 32'h55}) begin
            errors++;
            $display("FAIL r_after_wb: got %h want %h",
                     {state, instr_ready, rd, i_data}, {3'd0, 1'b1, 5'd0, 32'h55});
        end
    endtask

    task automatic test_load();
        instr_valid = 1'b1;
        instr       = 32'h8D280004;
        alu_result  = 32'h00000004;
        mem_rdata   = 32'h12345678;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if ({state, rs, rt} !== {3'd1, 5'd9, 5'd8}) begin
            errors++;
            $display("FAIL lw_decode: got %h want %h", {state, rs, rt}, {3'd1, 5'd9, 5'd8});
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({state, mem_req, mem_we, rd, instr_ready, i_data}
                !== {3'd3, 1'b1, 1'b0, 5'd0, 1'b0, 32'h4}) begin
                errors++;
                $display("FAIL lw_mem%0d: got %h want %h", k,
                         {state, mem_req, mem_we, rd, instr_ready, i_data},
                         {3'd3, 1'b1, 1'b0, 5'd0, 1'b0, 32'h4});
            end
            if (k == 2) begin
                mem_done  = 1'b1;
                mem_rdata = 32'hDEADBEEF;
            end
        end
        @(negedge clk);
        mem_done = 1'b0;
        checks++;
        if ({state, mem_req, rd, i_data} !== {3'd4, 1'b0, 5'd8, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL lw_wb: got %h want %h",
                     {state, mem_req, rd, i_data}, {3'd4, 1'b0, 5'd8, 32'hDEADBEEF});
        end
        @(negedge clk);
        checks++;
        if ({state, instr_ready, rd} !== {3'd0, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL lw_done: got %h want %h", {state, instr_ready, rd}, {3'd0, 1'b1, 5'd0});
        end
    endtask

    task automatic test_store();
        instr_valid = 1'b1;
        instr       = 32'hAD280004;
        alu_result  = 32'h00000044;
        mem_rdata   = 32'hCAFEF00D;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        mem_done = 1'b1;
        @(negedge clk);
        checks++;
        if ({state, mem_req, mem_we, rd} !== {3'd3, 1'b1, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL sw_mem: got %h want %h",
                     {state, mem_req, mem_we, rd}, {3'd3, 1'b1, 1'b1, 5'd0});
        end
        @(negedge clk);
        mem_done = 1'b0;
        checks++;
        if ({state, instr_ready, mem_req, mem_we, rd, i_data}
            !== {3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h44}) begin
            errors++;
            $display("FAIL sw_done: got %h want %h",
                     {state, instr_ready, mem_req, mem_we, rd, i_data},
                     {3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h44});
        end
    endtask

    task automatic test_rd_zero();
        instr_valid = 1'b1;
        instr       = 32'h012A0020;
        alu_result  = 32'h00000077;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({state, rd, i_data} !== {3'd4, 5'd0, 32'h77}) begin
            errors++;
            $display("FAIL rd0_wb: got %h want %h", {state, rd, i_data}, {3'd4, 5'd0, 32'h77});
        end
        @(negedge clk);
        checks++;
        if ({state, instr_ready} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL rd0_done: got %h want 1", {state, instr_ready});
        end
    endtask

    task automatic test_illegal();
        instr_valid = 1'b1;
        instr       = 32'hFC000000;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL ill_decode: got %0d want 1", state);
        end
        @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
        instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({state, instr_ready, illegal_op, rd} !== {3'd5, 1'b0, 1'b1, 5'd0}) begin
                errors++;
                $display("FAIL ill_halt%0d: got %h want %h", k,
                         {state, instr_ready, illegal_op, rd}, {3'd5, 1'b0, 1'b1, 5'd0});
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({state, illegal_op, instr_ready} !== {3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ill_reset: got %h want 0", {state, illegal_op, instr_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
        checks++;
        if ({state, instr_ready, illegal_op} !== {3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ill_fetch: got %h want %h",
                     {state, instr_ready, illegal_op}, {3'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_reset_mid_mem();
        instr_valid = 1'b1;
        instr       = 32'h8D280004;
        alu_result  = 32'h00000099;
        mem_done    = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({state, mem_req} !== {3'd3, 1'b1}) begin
            errors++;
            $display("FAIL rmid_in_mem: got %h want %h", {state, mem_req}, {3'd3, 1'b1});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({state, instr_ready, mem_req, mem_we, rd, rs, rt, illegal_op, i_data} !== 50'd0) begin
            errors++;
            $display("FAIL rmid_async: got %h want 0",
                     {state, instr_ready, mem_req, mem_we, rd, rs, rt, illegal_op, i_data});
        end
        @(negedge clk);
        rst      = 1'b0;
        mem_done = 1'b1;
        #1;
        checks++;
        if ({state, instr_ready} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL rmid_release: got %h want 0", {state, instr_ready});
        end
        @(negedge clk);
        mem_done = 1'b0;
        checks++;
        if ({state, instr_ready, rd, i_data} !== {3'd0, 1'b1, 5'd0, 32'h0}) begin
            errors++;
            $display("FAIL rmid_after: got %h want %h",
                     {state, instr_ready, rd, i_data}, {3'd0, 1'b1, 5'd0, 32'h0});
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        clk         = 1'b0;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        alu_result  = '0;
        mem_rdata   = '0;
        mem_done    = 1'b0;
        test_reset();
        test_rtype();
        test_load();
        test_store();
        test_rd_zero();
        test_illegal();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_decode_ctrl.md
INSTR_DECODE_CTRL -- requirements
Module: instr_decode_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 instr_valid  input  1  upstream fetch offers instr this cycle.
REQ-004 instr  input  32  instruction word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11].
REQ-005 instr_ready  output  1  block accepts instr; a transfer occurs when instr_valid and instr_ready are both high on a clk edge.
REQ-006 alu_result  input  32  execute-unit result, sampled at the end of EXEC.
REQ-007 mem_rdata  input  32  load data, sampled in MEM on the cycle mem_done is high.
REQ-008 mem_done  input  1  memory access complete.
REQ-009 mem_req  output  1  memory access request, high for every MEM cycle.
REQ-010 mem_we  output  1  store qualifier, high with mem_req for SW only.
REQ-011 rs, rt  output  5  register-slice read selects, driven from the latched instruction.
REQ-012 rd  output  5  register-slice write select; 0 outside WB.
REQ-013 i_data  output  32  write data to register slices.
REQ-014 state  output  3  current FSM state encoding (debug).
REQ-015 illegal_op  output  1  sticky illegal-opcode flag (see Configuration).

Function
REQ-016 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; other encodings SHALL return to FETCH next cycle.
REQ-017 FETCH: instr_ready=1; on transfer, latch instr into IR and go to DECODE; otherwise stay.
REQ-018 instr_ready SHALL be 0 in every state except FETCH.
REQ-019 DECODE: one cycle; rs=IR[25:21], rt=IR[20:16] from DECODE onward until the next transfer; next state EXEC for opcode 000000 (R), 100011 (LW), 101011 (SW), else illegal handling.
REQ-020 EXEC: one cycle; alu_result latched into result register; R -> WB, LW/SW -> MEM.
REQ-021 MEM: mem_req=1 until mem_done; on mem_done LW latches mem_rdata into result register and goes to WB, SW goes to FETCH; mem_done outside MEM ignored.
REQ-022 WB: one cycle; rd = IR[15:11] for R, IR[20:16] for LW; i_data = result register; then FETCH.
REQ-023 Destination 0 SHALL still pass through WB but rd output stays 0 (register 0 is never written).
REQ-024 i_data SHALL hold the last result register value outside WB; rd=0 is the only write qualifier.
REQ-025 Latency from transfer to WB: R 3 cycles, LW 4 + mem wait cycles; SW returns to FETCH 4 + wait cycles after transfer.
REQ-026 Back-to-back: an instruction may be accepted on the cycle after WB or after SW completion; no overlap of instructions.

Reset
REQ-027 While rst is high: state=FETCH, IR=0, result register=0, rs=rt=rd=0, i_data=0, mem_req=mem_we=0, illegal_op=0, instr_ready=0.
REQ-028 rst asserted mid-instruction SHALL abandon it immediately; no WB occurs; first instr_ready=1 on the first clk edge after rst falls.

Configuration
REQ-029 Macro ILLEGAL_TRAP_EN: when defined, an illegal opcode in DECODE sets illegal_op=1 and enters HALT, which persists (instr_ready=0, rd=0) until rst.
REQ-030 Without ILLEGAL_TRAP_EN: illegal opcode is a NOP, DECODE -> FETCH, illegal_op tied 0, HALT unreachable.

Verification
REQ-031 R-type instr=0x012A4020, alu_result=0x00000055 -> rs=9, rt=10 from DECODE; WB 3 cycles after transfer with rd=8, i_data=0x00000055; rd=0 in all other cycles.
REQ-032 LW instr=0x8D280004, mem_done after 2 wait cycles, mem_rdata=0xDEADBEEF -> mem_req high 3 cycles, mem_we=0, WB rd=8, i_data=0xDEADBEEF.
REQ-033 SW instr=0xAD280004, mem_done immediately -> mem_req=mem_we=1 one cycle, no WB, instr_ready=1 next cycle.
REQ-034 R-type with rd field 0 (instr=0x012A0020) -> WB state visited, rd output stays 0.
REQ-035 instr=0xFC000000: with ILLEGAL_TRAP_EN -> illegal_op=1, state=5, instr_ready=0 until rst; without -> state FETCH two cycles after transfer, illegal_op=0.
REQ-036 rst pulsed while in MEM of an LW -> all outputs at reset values asynchronously, no WB, instr_ready=1 one edge after release.
